// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sequencer sharing one 4-bit ALU between two requesters with ack watchdog
module alu_req_arbiter #(
  parameter int ACK_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] op0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] op1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic [1:0] gnt,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ack,
  output logic [3:0] rsp_out,
  output logic       rsp_cout,
  output logic [3:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic winner;
  logic last;
  logic [TO_W-1:0] wd;
  logic pick;
  logic ack_hit;
  logic expire;
  // winner selection: lone requester wins, contention goes to the one not served last
  always_comb begin
    pick = (req == 2'b11) ? ~last : req[1];
    ack_hit = rsp_ack[winner];
    expire = (ACK_TIMEOUT > 0) && (wd == TO_W'(ACK_TIMEOUT - 1));
  end
  assign busy = state != IDLE;
  // grant, operand launch, result capture and response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      winner <= 1'b0;
      last <= 1'b1;
      wd <= '0;
      gnt <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_out <= 4'h0;
      rsp_cout <= 1'b0;
      alu_opcode <= 4'h0;
      alu_a <= 4'h0;
      alu_b <= 4'h0;
      timeout_err <= 1'b0;
      op_count <= 8'h00;
    end else begin
      case (state)
        IDLE: if (req != 2'b00) begin
          alu_opcode <= pick ? op1 : op0;
          alu_a <= pick ? a1 : a0;
          alu_b <= pick ? b1 : b0;
          gnt <= pick ? 2'b10 : 2'b01;
          winner <= pick;
          state <= EXEC;
        end
        EXEC: begin
          gnt <= 2'b00;
          rsp_out <= alu_out;
          rsp_cout <= alu_cout;
          rsp_valid <= winner ? 2'b10 : 2'b01;
          wd <= '0;
          state <= RESP;
        end
        RESP: if (ack_hit) begin
          rsp_valid <= 2'b00;
          last <= winner;
          op_count <= op_count + 8'd1;
          wd <= '0;
          state <= IDLE;
        end else if (expire) begin
          rsp_valid <= 2'b00;
          timeout_err <= 1'b1;
          last <= winner;
          wd <= '0;
          state <= IDLE;
        end else if (ACK_TIMEOUT > 0) begin
          wd <= wd + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: randomized self-checking bench with a transaction-level arbitration model
module tb_alu_req_arbiter;
  logic clk = 0;
  logic rst = 0;
  logic [1:0] req = 0;
  logic [3:0] op0 = 0, a0 = 0, b0 = 0, op1 = 0, a1 = 0, b1 = 0;
  logic [1:0] gnt, rsp_valid;
  logic [1:0] rsp_ack = 0;
  logic [3:0] rsp_out, alu_opcode, alu_a, alu_b, alu_out;
  logic rsp_cout, alu_cout, busy, timeout_err;
  logic [7:0] op_count;
  int checks = 0;
  int failures = 0;
  int ref_last = 1;
  int ref_count = 0;

  alu_req_arbiter #(.ACK_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .a0(a0), .b0(b0), .op1(op1), .a1(a1), .b1(b1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_out(rsp_out), .rsp_cout(rsp_cout),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
  );

  function automatic logic [4:0] alu_fn(logic [3:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      4'b0100: alu_fn = {1'b0, a} + {1'b0, b};
      4'b1010: alu_fn = {1'b0, a & b};
      4'b1011: alu_fn = {1'b0, a | b};
      4'b1100: alu_fn = {1'b0, a ^ b};
      default: alu_fn = {1'b0, a} - {1'b0, b};
    endcase
  endfunction

  assign {alu_cout, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = 0;
    rsp_ack = 0;
    rst = 1;
    tick();
    rst = 0;
    ref_last = 1;
    ref_count = 0;
  endtask

  function automatic logic [1:0] exp_win(logic [1:0] r);
    exp_win = (r == 2'b11) ? ((ref_last == 1) ? 2'b01 : 2'b10) : r;
  endfunction

  function automatic logic [4:0] exp_res(logic [1:0] w);
    exp_res = w[1] ? alu_fn(op1, a1, b1) : alu_fn(op0, a0, b0);
  endfunction

  task automatic randomize_ops;
    op0 = 4'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
    op1 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
  endtask

  task automatic serve(input logic [1:0] r, output logic [1:0] g, output logic [1:0] v,
                       output logic [4:0] res, output int lat);
    req = r;
    g = 0;
    v = 0;
    res = 0;
    lat = 0;
    for (int i = 0; i < 8 && g == 0; i++) begin
      tick();
      g = gnt;
      lat = i + 1;
    end
    req = 0;
    if (g == 0) return;
    tick();
    v = rsp_valid;
    res = {rsp_cout, rsp_out};
    rsp_ack = g;
    tick();
    rsp_ack = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    #2;
    checks++;
    if ({gnt, rsp_valid, rsp_out, rsp_cout, busy, timeout_err, op_count, alu_opcode, alu_a, alu_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b valid=%b out=%h busy=%b err=%b cnt=%0d alu=%h/%h/%h, need all 0",
               gnt, rsp_valid, rsp_out, busy, timeout_err, op_count, alu_opcode, alu_a, alu_b);
    end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    op0 = 4'b0100; a0 = 4'd3; b0 = 4'd5;
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%b busy=%b, need 01 1", gnt, busy);
    end
    req = 0;
    tick();
    checks++;
    if (gnt !== 2'b00 || rsp_valid !== 2'b01 || rsp_out !== 4'd8 || rsp_cout !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: gnt=%b valid=%b out=%0d cout=%b, need 00 01 8 0", gnt, rsp_valid, rsp_out, rsp_cout);
    end
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 0;
    checks++;
    if (op_count !== 8'd1 || busy !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_ack: cnt=%0d busy=%b valid=%b, need 1 0 00", op_count, busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] g, v, w;
    logic [4:0] res;
    int lat;
    do_reset();
    op0 = 4'b1010; a0 = 4'hC; b0 = 4'hA;
    op1 = 4'b0100; a1 = 4'h9; b1 = 4'h9;
    for (int k = 0; k < 5; k++) begin
      w = exp_win(2'b11);
      serve(2'b11, g, v, res, lat);
      checks++;
      if (g !== w || v !== w || res !== exp_res(w) || lat != 1) begin
        failures++;
        $display("FAIL rr_op%0d: gnt=%b valid=%b res=%h lat=%0d, need %b %b %h 1", k, g, v, res, lat, w, w, exp_res(w));
      end
      ref_last = w[1] ? 1 : 0;
      ref_count++;
    end
    checks++;
    if (op_count !== 8'(ref_count)) begin
      failures++;
      $display("FAIL rr_count: got %0d need %0d", op_count, ref_count);
    end
  endtask

  task automatic test_only_req1;
    logic [1:0] g, v;
    logic [4:0] res;
    int lat;
    for (int k = 0; k < 3; k++) begin
      randomize_ops();
      serve(2'b10, g, v, res, lat);
      checks++;
      if (g !== 2'b10 || v !== 2'b10 || res !== exp_res(2'b10)) begin
        failures++;
        $display("FAIL only_req1_op%0d: gnt=%b valid=%b res=%h, need 10 10 %h", k, g, v, res, exp_res(2'b10));
      end
      ref_last = 1;
      ref_count++;
    end
  endtask

  task automatic test_ack_at_expiry;
    int n;
    randomize_ops();
    req = 2'b01;
    tick();
    req = 0;
    tick();
    n = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rsp_valid == 2'b01) n++;
    end
    checks++;
    if (n != 15) begin
      failures++;
      $display("FAIL expiry_hold: valid cycles=%0d need 15", n);
    end
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 0;
    ref_last = 0;
    ref_count++;
    checks++;
    if (timeout_err !== 1'b0 || op_count !== 8'(ref_count) || busy !== 1'b0) begin
      failures++;
      $display("FAIL ack_wins: err=%b cnt=%0d busy=%b, need 0 %0d 0", timeout_err, op_count, busy, ref_count);
    end
  endtask

  task automatic test_timeout;
    logic [1:0] g, v, w;
    logic [4:0] res;
    int n, lat;
    randomize_ops();
    w = exp_win(2'b11);
    req = 2'b11;
    tick();
    req = 0;
    tick();
    n = 0;
    for (int i = 0; i < 40 && rsp_valid != 0; i++) begin
      n++;
      tick();
    end
    ref_last = w[1] ? 1 : 0;
    checks++;
    if (n != 15 || timeout_err !== 1'b1 || op_count !== 8'(ref_count) || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout: valid cycles=%0d err=%b cnt=%0d busy=%b, need 15 1 %0d 0", n, timeout_err, op_count, busy, ref_count);
    end
    w = exp_win(2'b11);
    serve(2'b11, g, v, res, lat);
    ref_last = w[1] ? 1 : 0;
    ref_count++;
    checks++;
    if (g !== w || res !== exp_res(w) || timeout_err !== 1'b1 || op_count !== 8'(ref_count)) begin
      failures++;
      $display("FAIL after_timeout: gnt=%b res=%h err=%b cnt=%0d, need %b %h 1 %0d", g, res, timeout_err, op_count, w, exp_res(w), ref_count);
    end
  endtask

  task automatic test_wrong_ack;
    logic [4:0] e;
    randomize_ops();
    e = alu_fn(op0, a0, b0);
    req = 2'b01;
    tick();
    req = 0;
    tick();
    rsp_ack = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 2'b01 || busy !== 1'b1 || {rsp_cout, rsp_out} !== e) begin
        failures++;
        $display("FAIL wrong_ack_hold%0d: valid=%b busy=%b res=%h, need 01 1 %h", i, rsp_valid, busy, {rsp_cout, rsp_out}, e);
      end
    end
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 0;
    ref_last = 0;
    ref_count++;
    checks++;
    if (rsp_valid !== 2'b00 || op_count !== 8'(ref_count)) begin
      failures++;
      $display("FAIL wrong_ack_release: valid=%b cnt=%0d, need 00 %0d", rsp_valid, op_count, ref_count);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] g, v;
    logic [4:0] res;
    int lat;
    do_reset();
    op0 = 4'b0100; a0 = 4'd3; b0 = 4'd5;
    req = 2'b01;
    tick();
    req = 0;
    tick();
    #2 rst = 1;
    #1;
    checks++;
    if ({gnt, rsp_valid, rsp_out, rsp_cout, busy, timeout_err, op_count, alu_opcode, alu_a, alu_b} !== '0) begin
      failures++;
      $display("FAIL reset_mid: gnt=%b valid=%b out=%h busy=%b cnt=%0d alu_a=%h, need all 0", gnt, rsp_valid, rsp_out, busy, op_count, alu_a);
    end
    tick();
    rst = 0;
    ref_last = 1;
    ref_count = 0;
    randomize_ops();
    serve(2'b11, g, v, res, lat);
    ref_last = 0;
    ref_count++;
    checks++;
    if (g !== 2'b01 || res !== exp_res(2'b01) || op_count !== 8'd1) begin
      failures++;
      $display("FAIL reset_mid_prio: gnt=%b res=%h cnt=%0d, need 01 %h 1", g, res, op_count, exp_res(2'b01));
    end
  endtask

  task automatic test_wrap;
    logic [1:0] g, v, w, r;
    logic [4:0] res;
    int lat;
    do_reset();
    for (int k = 0; k < 256; k++) begin
      randomize_ops();
      r = 2'($urandom_range(1, 3));
      w = exp_win(r);
      serve(r, g, v, res, lat);
      checks++;
      if (g !== w || v !== w || res !== exp_res(w) || lat != 1) begin
        failures++;
        $display("FAIL wrap_op%0d: req=%b gnt=%b valid=%b res=%h lat=%0d, need %b %b %h 1", k, r, g, v, res, lat, w, w, exp_res(w));
      end
      ref_last = w[1] ? 1 : 0;
      ref_count = (ref_count + 1) % 256;
      if (k == 254) begin
        checks++;
        if (op_count !== 8'd255) begin
          failures++;
          $display("FAIL count_255: got %0d need 255", op_count);
        end
      end
    end
    checks++;
    if (op_count !== 8'(ref_count) || op_count !== 8'd0) begin
      failures++;
      $display("FAIL count_wrap: got %0d need 0", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_only_req1();
    test_ack_at_expiry();
    test_wrong_ack();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
